// File: rtl/jtdd_colmix.sv
// jtdd_colmix -- colour mixer and palette stage for the Double Dragon video path.
//
// Picks one of the char / scroll / object layers per pixel by transparency and
// priority, builds a 9-bit palette index and looks it up in two 512x8 palette
// RAMs (RG and B). It drives 4-bit RGB with blanking applied, and serves CPU
// reads and writes of the palette.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   pxl_cen            pixel clock enable (pulses at least 2 clk apart)
//   cen_Q              CPU bus enable qualifying writes
//   cpu_AB[9:0]        [9] RAM select (0 = RG, 1 = B), [8:0] palette entry
//   pal_cs, cpu_wrn    palette chip select, active-low write strobe
//   cpu_dout, pal_dout CPU write data / CPU read data
//   char/scr/obj_pxl   layer pixels {prio/unused, pal[2:0], pix[3:0]}
//   gfx_en[2:0]        layer enables: [0] char, [1] scroll, [2] obj
//   LHBL, LVBL         blanking inputs, active-low
//   LHBL_dly, LVBL_dly blanking aligned with RGB
//   red, green, blue   4-bit colour output
module jtdd_colmix #(
    parameter string SIMFILE_RG = "pal_rg.bin",
    parameter string SIMFILE_B  = "pal_b.bin"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       cen_Q,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic [7:0] char_pxl,
    input  logic [7:0] scr_pxl,
    input  logic [7:0] obj_pxl,
    input  logic [2:0] gfx_en,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    // ---------------- palette RAMs ----------------
    logic [7:0] ram_rg [512];
    logic [7:0] ram_b  [512];
    logic [7:0] cpu_rg, cpu_b;
    logic [7:0] vid_rg, vid_b;
    logic [8:0] pal_idx;

    logic cpu_we;
    assign cpu_we = cen_Q && pal_cs && !cpu_wrn;

    // NOTE: RAM contents are deliberately left out of the reset so the arrays
    // map onto block RAM; only the pipeline registers below are reset.
    // Both read ports are read-first: a write to the entry being read shows up
    // on the following read.
    always_ff @(posedge clk) begin
        if (cpu_we && !cpu_AB[9]) ram_rg[cpu_AB[8:0]] <= cpu_dout;
        if (cpu_we &&  cpu_AB[9]) ram_b[cpu_AB[8:0]]  <= cpu_dout;
        cpu_rg <= ram_rg[cpu_AB[8:0]];
        cpu_b  <= ram_b[cpu_AB[8:0]];
        // Video port runs every clk so data settles between pixel enables.
        vid_rg <= ram_rg[pal_idx];
        vid_b  <= ram_b[pal_idx];
    end

    assign pal_dout = cpu_AB[9] ? cpu_b : cpu_rg;

    // ---------------- S0: input register ----------------
    logic [6:0] char_r, obj_r;
    logic [7:0] scr_r;
    logic [2:0] gfx_r;
    logic       lhbl0, lvbl0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_r <= '0;
            obj_r  <= '0;
            scr_r  <= '0;
            gfx_r  <= '0;
            lhbl0  <= 1'b0;
            lvbl0  <= 1'b0;
        end else if (pxl_cen) begin
            char_r <= char_pxl[6:0];
            obj_r  <= obj_pxl[6:0];
            scr_r  <= scr_pxl;
            gfx_r  <= gfx_en;
            lhbl0  <= LHBL;
            lvbl0  <= LVBL;
        end
    end

    // ---------------- priority mux ----------------
    logic       char_op, scr_en, scr_op, obj_op;
    logic [8:0] idx_nx;
    logic       black_nx;

    assign char_op = gfx_r[0] && (char_r[3:0] != 4'd0);
    assign scr_en  = gfx_r[1];
    assign scr_op  = scr_en && (scr_r[3:0] != 4'd0);
    assign obj_op  = gfx_r[2] && (obj_r[3:0] != 4'd0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        idx_nx   = '0;
        black_nx = 1'b0;
        if (char_op)
            idx_nx = {2'b00, char_r};
        else if (scr_op && scr_r[7])
            idx_nx = {2'b10, scr_r[6:0]};
        else if (obj_op)
            idx_nx = {2'b01, obj_r};
        else if (scr_en)
            idx_nx = {2'b10, scr_r[6:0]};   // scroll backdrop, pix 0 included
        else
            black_nx = 1'b1;                // nothing to show: bypass palette
    end

    // ---------------- S1: index register ----------------
    logic black1, lhbl1, lvbl1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pal_idx <= '0;
            black1  <= 1'b0;
            lhbl1   <= 1'b0;
            lvbl1   <= 1'b0;
        end else if (pxl_cen) begin
            pal_idx <= idx_nx;
            black1  <= black_nx;
            lhbl1   <= lhbl0;
            lvbl1   <= lvbl0;
        end
    end

    // ---------------- S2: colour output ----------------
    logic show;
    assign show = !black1 && lhbl1 && lvbl1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            red      <= show ? vid_rg[3:0] : 4'd0;
            green    <= show ? vid_rg[7:4] : 4'd0;
            blue     <= show ? vid_b[3:0]  : 4'd0;
            LHBL_dly <= lhbl1;
            LVBL_dly <= lvbl1;
        end
    end

    // Bits that are stored or received but have no function here; the preload
    // file names are only meaningful to simulation models of the RAM.
    logic unused_sink;
    assign unused_sink = ^{char_pxl[7], obj_pxl[7], vid_b[7:4],
                           (SIMFILE_RG == SIMFILE_B)};

endmodule

// File: doc/jtdd_colmix.md
# jtdd_colmix

Colour mixer and palette stage for the Double Dragon video path, directly downstream of the scroll, character and object layers. Each pixel clock it picks the visible layer by transparency and priority rules, forms a 9-bit palette index, looks it up in CPU-writable palette RAM, and drives 4-bit RGB with blanking applied. It also serves CPU reads and writes of the palette.

## Interface
Parameters:
- SIMFILE_RG, "pal_rg.bin", RG RAM simulation preload
- SIMFILE_B, "pal_b.bin", B RAM simulation preload

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- pxl_cen  in  1  pixel clock enable; successive pulses are at least 2 clk apart
- cen_Q  in  1  CPU bus enable qualifying writes
- cpu_AB  in  10  [9] RAM select (0 = RG, 1 = B); [8:0] palette entry
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  CPU write strobe, active-low
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  CPU read data
- char_pxl  in  8  {unused, pal[2:0], pix[3:0]}
- scr_pxl  in  8  {prio, pal[2:0], pix[3:0]}, from the scroll layer
- obj_pxl  in  8  {unused, pal[2:0], pix[3:0]}
- gfx_en  in  3  layer enables: [0] char, [1] scroll, [2] obj
- LHBL, LVBL  in  1 each  horizontal and vertical blanking, active-low
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match RGB
- red, green, blue  out  4 each  colour output

## Operation
- Palette RAM is two 512x8 dual-port RAMs. RG byte: red = [3:0], green = [7:4]. B byte: blue = [3:0], bits [7:4] are stored and read back but unused.
- CPU write: cen_Q && pal_cs && !cpu_wrn writes cpu_dout to the RAM selected by cpu_AB[9], at entry cpu_AB[8:0].
- CPU read: pal_dout is the CPU-port output of the RAM selected by cpu_AB[9]. It is valid one clk after the address is stable.
- A layer is opaque when its pix[3:0] != 0 and its gfx_en bit is 1. A disabled scroll layer is treated as transparent.
- Priority, highest first:
  - char opaque: index {2'b00, char_pxl[6:0]}
  - scroll opaque and scr_pxl[7] = 1: index {2'b10, scr_pxl[6:0]}
  - obj opaque: index {2'b01, obj_pxl[6:0]}
  - scroll enabled (pix = 0 included): index {2'b10, scr_pxl[6:0]}
  - otherwise: force black. The palette is bypassed and a black flag travels with the pixel.
- Entries 0x180-0x1FF are reachable only by the CPU.

## Timing
- Reset (rst low): red, green, blue = 0; LHBL_dly = LVBL_dly = 0; all pipeline registers and the black flag = 0. RAM contents are not reset.
- Pipeline, advanced on pxl_cen only:
  - S0: register char/scr/obj pixels, gfx_en, LHBL and LVBL.
  - S1: register the palette index, black flag and blanking. The video read port is addressed from this register. RAM data is valid 1 clk later, before the next pxl_cen.
  - S2: register red/green/blue from RAM data, or 0 if the black flag is set or either delayed blank is low. Register LHBL_dly and LVBL_dly.
- Latency: inputs sampled at pxl_cen tick N appear on the outputs after tick N+2. The output is 3 pxl_cen deep, counting the input register.
- Without pxl_cen all registers hold, except that RAM read data follows the address.
- Simultaneous CPU write and video read of the same entry: the video port returns the old value. The new value is visible from the next read.
- rst asserted mid-frame clears outputs immediately, asynchronously. After release, the first valid pixel appears after 3 pxl_cen pulses.
- A CPU write is never blocked and has no wait state.

## Test plan
- Write RG[0x105] = 0xA5 and B[0x105] = 0x03. Drive scr_pxl = 0x05, char = obj = 0x00, gfx_en = 3'b111, blanks high. Expect RGB = 5, A, 3 three pxl_cen later, with LHBL_dly = LVBL_dly = 1.
- Priority: char_pxl = 0x12, obj_pxl = 0x34, scr_pxl = 0x86 selects index 0x012. Change char_pxl to 0x10: index is 0x106 (scroll prio wins). Then clear scr_pxl[7]: index is 0x0B4.
- gfx_en = 3'b000 with all layers opaque -> RGB = 0,0,0, even with entry 0x000 = 0xFF.
- LHBL low for one pixel mid-line -> that pixel's RGB = 0, and LHBL_dly goes low exactly aligned with it.
- CPU readback: write B[0x1F0] = 0xC7 -> pal_dout = 0xC7 one clk after the address with cpu_AB[9] = 1. Same entry with cpu_AB[9] = 0 returns the RG contents.
- Assert rst during active video -> all outputs are 0 asynchronously. After release, outputs stay 0 until the 3rd pxl_cen.
